// File: rtl/delay_pkg.sv
// Shared definitions for the delay measurement checker.
//  - FSM state encoding
//  - one-hot result classes, bit order {pass, early, late, timeout}
//  - DELAY_PARAM_CHECK: elaboration-time sanity check of the window parameters
`define DELAY_PARAM_CHECK(MN, MX, TO, W) \
  if (!(((MN) <= (MX)) && ((MX) < (TO)) && ((TO) < (2 ** (W))))) begin : g_param_check \
    $error("delay_measure: parameters need MIN_DLY <= MAX_DLY < TIMEOUT < 2**CNT_W"); \
  end

package delay_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [3:0] RES_NONE    = 4'b0000;
  localparam logic [3:0] RES_PASS    = 4'b1000;
  localparam logic [3:0] RES_EARLY   = 4'b0100;
  localparam logic [3:0] RES_LATE    = 4'b0010;
  localparam logic [3:0] RES_TIMEOUT = 4'b0001;

endpackage

// File: rtl/delay_measure_sat_counter.sv
// sat_counter: saturating up-counter.
//  clk  in  1  clock, rising edge
//  rst  in  1  asynchronous active-high reset, clears q
//  inc  in  1  increment request, ignored once q is all ones
//  q    out W  count value
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/delay_measure.sv
// delay_measure: receive-side checker for delayed-enable generators.
// A start event launches a cycle count that ends when sig_in is sampled high;
// the delay is then classified against the [MIN_DLY, MAX_DLY] window.
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous active-high reset
//  start     in   1      begin measurement, sampled only in IDLE
//  sig_in    in   1      monitored level, synchronous to clk
//  busy      out  1      high while counting
//  done      out  1      one-cycle result-valid pulse
//  measured  out  CNT_W  delay of the last measurement in cycles
//  pass      out  1      MIN_DLY <= measured <= MAX_DLY
//  early     out  1      measured < MIN_DLY
//  late      out  1      MAX_DLY < measured < TIMEOUT
//  timeout   out  1      sig_in never rose within TIMEOUT cycles
//  err_cnt   out  ERR_W  saturating count of non-pass results
module delay_measure
  import delay_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MIN_DLY = 8,
  parameter int MAX_DLY = 12,
  parameter int TIMEOUT = 255,
  parameter int ERR_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] measured,
  output logic             pass,
  output logic             early,
  output logic             late,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt
);

  `DELAY_PARAM_CHECK(MIN_DLY, MAX_DLY, TIMEOUT, CNT_W)

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DLY);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DLY);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       res;
  logic             err_inc;

  // A rise sampled exactly on the TIMEOUT cycle is outside the late window,
  // so it is reported as a timeout to keep the flags one-hot.
  function automatic logic [3:0] classify(input logic [CNT_W-1:0] m);
    if (m < MIN_C)      return RES_EARLY;
    else if (m <= MAX_C) return RES_PASS;
    else if (m < TO_C)   return RES_LATE;
    else                 return RES_TIMEOUT;
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = sig_in ? S_REPORT : S_COUNT;
      S_COUNT:  if (sig_in || (cnt == TO_C)) state_nx = S_REPORT;
      S_REPORT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // cnt starts at 1 on the start edge, so its value on the edge that samples
  // sig_in high equals the number of edges since start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      measured <= '0;
      res      <= RES_NONE;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_COUNT);
      done  <= (state_nx == S_REPORT);
      case (state)
        S_IDLE: begin
          if (start) begin
            if (sig_in) begin
              measured <= '0;
              res      <= RES_EARLY;
            end else begin
              cnt <= CNT_W'(1);
              res <= RES_NONE;
            end
          end
        end
        S_COUNT: begin
          if (sig_in) begin
            measured <= cnt;
            res      <= classify(cnt);
          end else if (cnt == TO_C) begin
            measured <= TO_C;
            res      <= RES_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign {pass, early, late, timeout} = res;

  assign err_inc = (state == S_REPORT) && (res != RES_PASS);

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .q   (err_cnt)
  );

endmodule
